mmcm_servo_controller: RTL and testbench

- Frequency servo for an MMCM running in dynamic phase-shift mode.
- Counts rising edges of a reference signal and of the MMCM feedback output over a fixed window of the 300 MHz system clock.
- Issues single-step phase-shift commands (psen/psincdec with psdone handshake) that pull the feedback toward the reference.
- Sits beside the MMCM in the clocking top; the 156.25 MHz reference path is divided upstream before it reaches this block.

---
 rtl/mmcm_servo_controller_if.sv | 9 +
 rtl/mmcm_servo_controller.sv | 163 ++++++++++++++++
 tb/tb_mmcm_servo_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_servo_controller_if.sv
// rtl/mmcm_servo_controller_if.sv - MMCM dynamic phase-shift handshake (psen/psincdec/psdone)
interface mmcm_servo_controller_if;
  logic psen;
  logic psincdec;
  logic psdone;

  modport master (output psen, output psincdec, input psdone);
  modport slave  (input psen, input psincdec, output psdone);
endinterface

// File: rtl/mmcm_servo_controller.sv
// rtl/mmcm_servo_controller.sv - frequency servo that nudges an MMCM with single phase-shift steps
module mmcm_servo_controller #(
  parameter int WINDOW_CYCLES  = 4096,
  parameter int CNT_W          = 16,
  parameter int DEADBAND       = 1,
  parameter int PSDONE_TIMEOUT = 255,
  parameter int PHASE_W        = 16,
  parameter int LOCK_WINDOWS   = 4
) (
  input  logic                      clk_in_300Mhz,
  input  logic                      reset_in,
  input  logic                      ref_sig_in,
  input  logic                      fb_sig_in,
  input  logic                      mmcm_locked,
  mmcm_servo_controller_if.master   ps,
  output logic [CNT_W-1:0]          ref_count,
  output logic [CNT_W-1:0]          fb_count,
  output logic signed [CNT_W:0]     freq_err,
  output logic signed [PHASE_W-1:0] phase_pos,
  output logic                      servo_locked,
  output logic                      timeout_err
);
  localparam int ERR_W  = CNT_W + 1;
  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int WAIT_W = $clog2(PSDONE_TIMEOUT + 1);
  localparam int IB_W   = $clog2(LOCK_WINDOWS + 1);
  localparam logic [WIN_W-1:0]          WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WAIT_W-1:0]         WAIT_LAST = WAIT_W'(PSDONE_TIMEOUT - 1);
  localparam logic [IB_W-1:0]           IB_FULL   = IB_W'(LOCK_WINDOWS);
  localparam logic [IB_W-1:0]           IB_PRE    = IB_W'(LOCK_WINDOWS - 1);
  localparam logic signed [CNT_W:0]     DB_POS    = ERR_W'(DEADBAND);
  localparam logic signed [CNT_W:0]     DB_NEG    = -DB_POS;
  localparam logic signed [PHASE_W-1:0] PH_MAX    = {1'b0, {(PHASE_W-1){1'b1}}};
  localparam logic signed [PHASE_W-1:0] PH_MIN    = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic signed [PHASE_W-1:0] PH_ONE    = PHASE_W'(1);

  typedef enum logic [2:0] {IDLE, MEASURE, EVAL, PS_REQ, PS_WAIT} state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 ref_sync_q, fb_sync_q;
  logic [1:0]                 lock_sync_q;
  logic [WIN_W-1:0]           win_q;
  logic [CNT_W-1:0]           ref_cnt_q, fb_cnt_q;
  logic [WAIT_W-1:0]          wait_q;
  logic [IB_W-1:0]            inband_q;
  logic                       dir_q;
  logic [CNT_W-1:0]           ref_count_q, fb_count_q;
  logic signed [CNT_W:0]      freq_err_q;
  logic signed [PHASE_W-1:0]  phase_q;
  logic                       locked_q, tmo_q;

  logic                       ref_edge, fb_edge, lock_s, lock_lost, too_slow, too_fast;
  logic signed [CNT_W:0]      err_d;

  assign ref_edge  = ref_sync_q[1] & ~ref_sync_q[2];
  assign fb_edge   = fb_sync_q[1] & ~fb_sync_q[2];
  assign lock_s    = lock_sync_q[1];
  assign lock_lost = (state_q != IDLE) && !lock_s;
  assign err_d     = $signed({1'b0, fb_cnt_q}) - $signed({1'b0, ref_cnt_q});
  assign too_slow  = err_d < DB_NEG;
  assign too_fast  = err_d > DB_POS;

  always_comb begin
    state_d = state_q;
    ps.psen = 1'b0;
    if (lock_lost) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (lock_s) state_d = MEASURE;
        MEASURE: if (win_q == WIN_LAST) state_d = EVAL;
        EVAL:    state_d = (too_slow || too_fast) ? PS_REQ : MEASURE;
        PS_REQ: begin
          ps.psen = 1'b1;
          state_d = PS_WAIT;
        end
        PS_WAIT: if (ps.psdone || wait_q == WAIT_LAST) state_d = MEASURE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in_300Mhz) begin
    if (reset_in) begin
      state_q     <= IDLE;
      ref_sync_q  <= '0;
      fb_sync_q   <= '0;
      lock_sync_q <= '0;
      win_q       <= '0;
      ref_cnt_q   <= '0;
      fb_cnt_q    <= '0;
      wait_q      <= '0;
      inband_q    <= '0;
      dir_q       <= 1'b0;
      ref_count_q <= '0;
      fb_count_q  <= '0;
      freq_err_q  <= '0;
      phase_q     <= '0;
      locked_q    <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      ref_sync_q  <= {ref_sync_q[1:0], ref_sig_in};
      fb_sync_q   <= {fb_sync_q[1:0], fb_sig_in};
      lock_sync_q <= {lock_sync_q[0], mmcm_locked};
      state_q     <= state_d;
      // Lock loss outranks whatever the current state would have done this cycle.
      if (lock_lost) begin
        win_q     <= '0;
        ref_cnt_q <= '0;
        fb_cnt_q  <= '0;
        wait_q    <= '0;
        inband_q  <= '0;
        locked_q  <= 1'b0;
      end else begin
        unique case (state_q)
          MEASURE: begin
            win_q <= (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
            if (ref_edge && ref_cnt_q != '1) ref_cnt_q <= ref_cnt_q + CNT_W'(1);
            if (fb_edge && fb_cnt_q != '1)   fb_cnt_q  <= fb_cnt_q + CNT_W'(1);
          end
          EVAL: begin
            ref_count_q <= ref_cnt_q;
            fb_count_q  <= fb_cnt_q;
            freq_err_q  <= err_d;
            ref_cnt_q   <= '0;
            fb_cnt_q    <= '0;
            if (too_slow || too_fast) begin
              dir_q    <= too_slow;
              inband_q <= '0;
              locked_q <= 1'b0;
            end else begin
              if (inband_q != IB_FULL) inband_q <= inband_q + IB_W'(1);
              if (inband_q >= IB_PRE)  locked_q <= 1'b1;
            end
          end
          PS_REQ: wait_q <= '0;
          PS_WAIT: begin
            if (ps.psdone) begin
              if (dir_q) begin
                if (phase_q != PH_MAX) phase_q <= phase_q + PH_ONE;
              end else if (phase_q != PH_MIN) begin
                phase_q <= phase_q - PH_ONE;
              end
            end else if (wait_q == WAIT_LAST) begin
              tmo_q <= 1'b1;
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ps.psincdec  = dir_q;
  assign ref_count    = ref_count_q;
  assign fb_count     = fb_count_q;
  assign freq_err     = freq_err_q;
  assign phase_pos    = phase_q;
  assign servo_locked = locked_q;
  assign timeout_err  = tmo_q;
endmodule

// File: tb/tb_mmcm_servo_controller.sv
// tb/tb_mmcm_servo_controller.sv - randomized bench with a window-timeline reference model
module tb_mmcm_servo_controller;
  localparam int W    = 64;
  localparam int CW   = 5;
  localparam int DB   = 1;
  localparam int TO   = 20;
  localparam int PW   = 4;
  localparam int LW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PMAX = (1 << (PW - 1)) - 1;
  localparam int PMIN = -(1 << (PW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ref_i = 1'b0, fb_i = 1'b0, lock_i = 1'b0;
  logic [CW-1:0]        ref_count, fb_count;
  logic signed [CW:0]   freq_err;
  logic signed [PW-1:0] phase_pos;
  logic                 servo_locked, timeout_err;

  mmcm_servo_controller_if ps_if ();

  mmcm_servo_controller #(
    .WINDOW_CYCLES(W), .CNT_W(CW), .DEADBAND(DB),
    .PSDONE_TIMEOUT(TO), .PHASE_W(PW), .LOCK_WINDOWS(LW)
  ) dut (
    .clk_in_300Mhz(clk), .reset_in(rst),
    .ref_sig_in(ref_i), .fb_sig_in(fb_i), .mmcm_locked(lock_i),
    .ps(ps_if),
    .ref_count(ref_count), .fb_count(fb_count), .freq_err(freq_err),
    .phase_pos(phase_pos), .servo_locked(servo_locked), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  int ref_half = 0, fb_half = 1, rc = 0, fc = 0;
  always @(negedge clk) begin
    rc++;
    fc++;
    if (ref_half == 0) begin ref_i = 1'b0; rc = 0; end
    else if (rc >= ref_half) begin ref_i = ~ref_i; rc = 0; end
    if (fb_half == 0) begin fb_i = 1'b0; fc = 0; end
    else if (fc >= fb_half) begin fb_i = ~fb_i; fc = 0; end
  end

  bit resp_en = 1'b1, spur_en = 1'b0, pending = 1'b0;
  int d_min = 0, d_max = 0, dcnt = 0;
  initial ps_if.psdone = 1'b0;
  always @(negedge clk) begin
    ps_if.psdone = 1'b0;
    if (pending) begin
      if (dcnt == 0) begin ps_if.psdone = 1'b1; pending = 1'b0; end
      else dcnt--;
    end else if (spur_en && $urandom_range(0, 99) < 2) begin
      ps_if.psdone = 1'b1;
    end
    if (ps_if.psen && resp_en) begin
      pending = 1'b1;
      dcnt = $urandom_range(d_min, d_max);
    end
  end

  // m_t is the position on the window timeline: -1 idle, 0..W-1 measuring,
  // W evaluating, W+1 requesting, W+2+k the k-th cycle of waiting for psdone.
  int m_t = -1;
  int m_rc = 0, m_fc = 0, m_ref = 0, m_fb = 0, m_err = 0, m_phase = 0, m_inband = 0;
  bit m_locked = 0, m_tmo = 0, m_dir = 0;
  logic [2:0] m_rs = '0, m_fs = '0;
  logic [1:0] m_ls = '0;
  bit s_pd, re, fe, lk;

  always @(posedge clk) begin
    s_pd = ps_if.psdone;
    if (rst) begin
      m_t = -1; m_rc = 0; m_fc = 0; m_ref = 0; m_fb = 0; m_err = 0; m_phase = 0;
      m_inband = 0; m_locked = 0; m_tmo = 0; m_dir = 0;
      m_rs = '0; m_fs = '0; m_ls = '0;
    end else begin
      re = m_rs[1] && !m_rs[2];
      fe = m_fs[1] && !m_fs[2];
      lk = m_ls[1];
      if (m_t != -1 && !lk) begin
        m_t = -1; m_rc = 0; m_fc = 0; m_inband = 0; m_locked = 0;
      end else if (m_t == -1) begin
        if (lk) m_t = 0;
      end else if (m_t < W) begin
        if (re && m_rc < CMAX) m_rc++;
        if (fe && m_fc < CMAX) m_fc++;
        m_t++;
      end else if (m_t == W) begin
        m_ref = m_rc; m_fb = m_fc; m_err = m_fc - m_rc; m_rc = 0; m_fc = 0;
        if (m_err < -DB || m_err > DB) begin
          m_dir = (m_err < -DB); m_t = W + 1; m_inband = 0; m_locked = 0;
        end else begin
          m_inband++; if (m_inband >= LW) m_locked = 1; m_t = 0;
        end
      end else if (m_t == W + 1) begin
        m_t = W + 2;
      end else if (s_pd) begin
        m_phase = m_dir ? ((m_phase < PMAX) ? m_phase + 1 : PMAX)
                        : ((m_phase > PMIN) ? m_phase - 1 : PMIN);
        m_t = 0;
      end else if (m_t - (W + 2) == TO - 1) begin
        m_tmo = 1; m_t = 0;
      end else begin
        m_t++;
      end
      m_rs = {m_rs[1:0], ref_i};
      m_fs = {m_fs[1:0], fb_i};
      m_ls = {m_ls[0], lock_i};
    end
    #1;
    chk("m_psen", int'(ps_if.psen), (m_t == W + 1) ? 1 : 0);
    if (m_t == W + 1) chk("m_psincdec", int'(ps_if.psincdec), int'(m_dir));
    chk("m_ref_count", int'(ref_count), m_ref);
    chk("m_fb_count", int'(fb_count), m_fb);
    chk("m_freq_err", int'(freq_err), m_err);
    chk("m_phase_pos", int'(phase_pos), m_phase);
    chk("m_servo_locked", int'(servo_locked), int'(m_locked));
    chk("m_timeout_err", int'(timeout_err), int'(m_tmo));
  end

  task automatic wait_psen(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #1;
      if (ps_if.psen) begin ok = 1'b1; break; end
    end
  endtask

  int lat, pb;
  bit ok;

  initial begin
    rst = 1'b1; lock_i = 1'b1; ref_half = 0; fb_half = 1;
    repeat (300) @(posedge clk);
    #1;
    chk("rst_psen", int'(ps_if.psen), 0);
    chk("rst_ref_count", int'(ref_count), 0);
    chk("rst_freq_err", int'(freq_err), 0);
    chk("rst_phase_pos", int'(phase_pos), 0);
    chk("rst_servo_locked", int'(servo_locked), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);

    @(negedge clk) rst = 1'b0;
    lat = -1;
    for (int n = 1; n <= W + 20; n++) begin
      @(posedge clk);
      #1;
      if (ps_if.psen) begin lat = n; break; end
    end
    chk("first_psen_latency", lat, W + 4);
    chk("sat_fb_count", int'(fb_count), CMAX);
    chk("sat_ref_count", int'(ref_count), 0);
    chk("sat_freq_err", int'(freq_err), 31);
    chk("fast_psincdec", int'(ps_if.psincdec), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("phase_after_first_ack", int'(phase_pos), -1);
    repeat (15 * (W + 10)) @(posedge clk);
    #1;
    chk("phase_saturated_min", int'(phase_pos), -8);
    chk("locked_while_fast", int'(servo_locked), 0);

    @(negedge clk); ref_half = 3; fb_half = 3;
    repeat (10 * (W + 6)) @(posedge clk);
    #1;
    chk("locked_equal_freq", int'(servo_locked), 1);

    @(negedge clk); ref_half = 2; fb_half = 0; d_min = 12; d_max = 12;
    wait_psen(4 * (W + 20), ok);
    chk("slow_psen_seen", int'(ok), 1);
    wait_psen(4 * (W + 20), ok);
    chk("slow_psen_seen2", int'(ok), 1);
    chk("slow_psincdec", int'(ps_if.psincdec), 1);
    chk("slow_ref_count", int'(ref_count), 16);
    chk("slow_fb_count", int'(fb_count), 0);
    chk("slow_freq_err", int'(freq_err), -16);
    pb = int'(phase_pos);
    @(posedge clk);
    #1;
    chk("psen_one_cycle", int'(ps_if.psen), 0);
    repeat (15) @(posedge clk);
    #1;
    chk("phase_after_slow_ack", int'(phase_pos), pb + 1);

    @(negedge clk) resp_en = 1'b0;
    wait_psen(4 * (W + 20), ok);
    chk("timeout_psen_seen", int'(ok), 1);
    pb = int'(phase_pos);
    repeat (TO + 3) @(posedge clk);
    #1;
    chk("timeout_set", int'(timeout_err), 1);
    chk("timeout_phase_kept", int'(phase_pos), pb);
    repeat (2 * W) @(posedge clk);
    #1;
    chk("timeout_sticky", int'(timeout_err), 1);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_cleared_by_reset", int'(timeout_err), 0);
    chk("phase_cleared_by_reset", int'(phase_pos), 0);

    @(negedge clk); rst = 1'b0; ref_half = 0; fb_half = 1;
    wait_psen(W + 20, ok);
    chk("lockloss_psen_seen", int'(ok), 1);
    repeat (5) @(posedge clk);
    @(negedge clk) lock_i = 1'b0;
    pb = int'(phase_pos);
    repeat (3) @(posedge clk);
    #1;
    chk("lockloss_psen", int'(ps_if.psen), 0);
    chk("lockloss_servo_locked", int'(servo_locked), 0);
    chk("lockloss_phase_kept", int'(phase_pos), pb);
    chk("lockloss_fb_count_kept", int'(fb_count), CMAX);
    @(negedge clk) lock_i = 1'b1;
    wait_psen(2 * W + 20, ok);
    chk("relock_restarts", int'(ok), 1);

    @(negedge clk); resp_en = 1'b1; d_min = 0; d_max = 25; spur_en = 1'b1;
    for (int s = 0; s < 30; s++) begin
      @(negedge clk);
      ref_half = $urandom_range(1, 5);
      fb_half  = $urandom_range(0, 6);
      lock_i   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(50, 500)) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
